kd_tree_node_loader: RTL and testbench

- Write-side front end for the KD-tree internal-node array: accepts a stream of node configuration words over a valid/ready handshake.
- Steers each word to exactly one internal node by driving a one-hot write enable plus a broadcast wdata bus, in breadth-first node order 0..NUM_NODES-1.
- Sits between the host/receiver dequeue and the per-node wen/wdata inputs.
- Flags words whose dimension index is out of range.

---
 rtl/kd_tree_node_loader.sv | 61 ++++++
 tb/tb_kd_tree_node_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/kd_tree_node_loader.sv
// kd_tree_node_loader: streams node configuration words into the KD-tree internal-node array in breadth-first order.
module kd_tree_node_loader #(
  parameter int NUM_NODES = 31,
  parameter int STORAGE_WIDTH = 22,
  parameter int IDX_WIDTH = 11,
  parameter int NUM_DIMS = 5,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic [NUM_NODES-1:0]     wen,
  output logic [STORAGE_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0]    node_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err_idx
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic hs, last, bad_idx;
  assign in_ready = state == LOAD;
  assign hs = in_valid & in_ready;
  assign last = node_addr == ADDR_WIDTH'(NUM_NODES - 1);
  assign bad_idx = in_data[IDX_WIDTH-1:0] >= IDX_WIDTH'(NUM_DIMS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wen <= '0;
      wdata <= '0;
      node_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_idx <= 1'b0;
    end else begin
      wen <= hs ? NUM_NODES'(1) << node_addr : '0;
      if (hs) wdata <= in_data;
      case (state)
        LOAD: if (hs) begin
          node_addr <= last ? '0 : node_addr + ADDR_WIDTH'(1);
          if (bad_idx) err_idx <= 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: if (start) begin
          state <= LOAD;
          node_addr <= '0;
          busy <= 1'b1;
          done <= 1'b0;
          err_idx <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kd_tree_node_loader.sv
// tb_kd_tree_node_loader: directed loads checked every cycle against a word-counting model plus literal pins.
module tb_kd_tree_node_loader;
  localparam int N = 31;
  localparam int W = 22;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, busy, done, err_idx;
  logic [N-1:0] wen;
  logic [W-1:0] wdata;
  logic [4:0] node_addr;
  int tests = 0, fails = 0, pulses = 0;
  bit cmp_on = 1'b0;
  logic [W-1:0] nodes [N];
  int m_phase = 0, m_cnt = 0;
  bit m_err = 1'b0, m_done = 1'b0;
  logic [N-1:0] m_wen = '0;
  logic [W-1:0] m_wdata = '0;

  always #5 clk = ~clk;

  kd_tree_node_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wen(wen), .wdata(wdata), .node_addr(node_addr),
    .busy(busy), .done(done), .err_idx(err_idx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int i, input int bad);
    return i == bad ? 22'b0000000001000000000111 : {11'(i + 1), 11'(i % 5)};
  endfunction

  // Model: phase 0 idle, 1 loading, 2 done; counts accepted words.
  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_err = 0; m_done = 0; m_wen = '0; m_wdata = '0;
    end else begin
      acc = m_phase == 1 && in_valid;
      m_wen = acc ? N'(1) << m_cnt : '0;
      if (acc) begin
        m_wdata = in_data;
        if (in_data[10:0] >= 11'd5) m_err = 1;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_phase = 2; m_done = 1;
        end
      end else if (m_phase != 1 && start) begin
        m_phase = 1; m_cnt = 0; m_err = 0; m_done = 0;
      end
    end
  end

  always @(negedge clk) if (cmp_on) begin
    chk("in_ready", in_ready, m_phase == 1);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_done);
    chk("err_idx", err_idx, m_err);
    chk("node_addr", node_addr, m_cnt);
    chk("wen", wen, m_wen);
    chk("wdata", wdata, m_wdata);
    chk("wen_onehot", $countones(wen) <= 1, 1);
    if (wen != 0) begin
      nodes[$clog2(wen)] = wdata;
      pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input bit gap, input int bad, input int mid_start, input int abort);
    for (int i = 0; i < N; i++) nodes[i] = '0;
    pulses = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err_idx, 0);
    for (int i = 0; i < N; i++) begin
      if (i == abort) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_addr", node_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      in_valid = 1'b1;
      in_data = word(i, bad);
      start = i == mid_start;
      step();
      start = 1'b0;
      if (i == 0) begin
        chk("first_wen", wen, 31'h1);
        chk("first_wdata", wdata, 22'h000800);
      end
      if (i == mid_start) chk("mid_start_addr", node_addr, 11);
      if (i == bad) chk("bad_err", err_idx, 1);
      if (gap) begin
        in_valid = 1'b0;
        step();
        chk("stall_wen", wen, 0);
      end
    end
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    chk("load_done", done, 1);
    chk("load_addr", node_addr, 0);
    chk("load_err", err_idx, bad >= 0);
    chk("load_pulses", pulses, 31);
    for (int i = 0; i < N; i++) chk("node_word", nodes[i], word(i, bad));
    chk("node30_pin", nodes[30], 22'h00F800);
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    cmp_on = 1'b1;
    in_valid = 1'b1;
    in_data = 22'h3FFFFF;
    repeat (3) step();
    chk("idle_ready", in_ready, 0);
    chk("idle_wen", wen, 0);
    in_valid = 1'b0;
    load(1'b0, -1, -1, -1);
    load(1'b1, -1, -1, -1);
    load(1'b0, 3, -1, -1);
    chk("bad_node3_pin", nodes[3], 22'h001007);
    load(1'b0, -1, 10, -1);
    load(1'b0, -1, -1, 12);
    load(1'b0, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
